// File: rtl/reg_stack_scanner_pkg.sv
// Shared definitions for the register stack scanner: FSM state encoding
// and default timing parameters.
package reg_stack_scanner_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_CAPT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_ADDR = ST_ADDR,
        S_CAPT = ST_CAPT,
        S_HOLD = ST_HOLD,
        S_DONE = ST_DONE
    } scan_state_t;

    localparam int unsigned TICK_DIV_DEF        = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/reg_stack_scanner_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, optional stable-count debouncer
// (enabled by SCANNER_DEBOUNCE_EN), and a registered 1-cycle rising-edge pulse.
module btn_debounce
    import reg_stack_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic r_pulse;
    logic w_level;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // Bring the raw button into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SCANNER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // Accept a new level only after it has been seen on consecutive samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= CNT_LOAD;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= CNT_LOAD;
        end else if (r_cnt == '0) begin
            r_stable <= r_sync2;
            r_cnt    <= CNT_LOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync2;
`endif

    // Registered rising-edge detector on the conditioned level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_pulse   <= w_level & ~r_level_d;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/reg_stack_scanner.sv
// Register stack scanner: walks read addresses 0..2^ADDR_W-1, captures each
// word and presents it with its address to the display path. Advance by Step
// button or by a timed tick while Auto is high. Optional button debouncing is
// selected with the SCANNER_DEBOUNCE_EN macro.
//
// state | meaning
// IDLE  | waiting for Start, nothing displayed yet
// ADDR  | read address driven, one cycle of settle time
// CAPT  | capture read data into the display registers
// HOLD  | word displayed, wait for Step or Auto tick
// DONE  | top address shown and released, last word stays displayed
module reg_stack_scanner
    import reg_stack_scanner_pkg::*;
#(
    parameter int unsigned ADDR_W          = 5,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_auto,
    input  logic [DATA_W-1:0] i_r_data,
    output logic [ADDR_W-1:0] o_r_addr,
    output logic [DATA_W-1:0] o_disp_data,
    output logic [ADDR_W-1:0] o_disp_addr,
    output logic              o_disp_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be at least 2");
    end

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [DATA_W-1:0] r_disp_data;
    logic [ADDR_W-1:0] r_disp_addr;
    logic              r_disp_valid;
    logic              r_auto_s1;
    logic              r_auto_s2;
    logic              w_start_pulse;
    logic              w_step_pulse;
    logic              w_tick_hit;
    logic              w_capture;
    logic              w_clr_valid;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_start),
        .o_pulse (w_start_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_step),
        .o_pulse (w_step_pulse)
    );

    // Auto is a level switch: synchronize only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_auto_s1 <= i_auto;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // Next-state, address and tick down-counter; the counter reloads on any
    // state change and freezes in HOLD while Auto is low.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_tick_nxt  = TICK_LOAD;
        w_capture   = 1'b0;
        w_clr_valid = 1'b0;
        w_tick_hit  = r_auto_s2 && (r_tick == '0);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_pulse) begin
                    w_state_nxt = S_ADDR;
                    w_addr_nxt  = '0;
                    w_clr_valid = 1'b1;
                end
            end
            S_ADDR: w_state_nxt = S_CAPT;
            S_CAPT: begin
                w_state_nxt = S_HOLD;
                w_capture   = 1'b1;
            end
            S_HOLD: begin
                if (w_step_pulse || w_tick_hit) begin
                    if (r_addr == ADDR_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = S_ADDR;
                    end
                end else if (r_auto_s2) begin
                    w_tick_nxt = r_tick - 1'b1;
                end else begin
                    w_tick_nxt = r_tick;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, address and tick registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_tick  <= TICK_LOAD;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Display registers: load on capture, valid drops when a new scan starts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_disp_data  <= '0;
            r_disp_addr  <= '0;
            r_disp_valid <= 1'b0;
        end else if (w_capture) begin
            r_disp_data  <= i_r_data;
            r_disp_addr  <= r_addr;
            r_disp_valid <= 1'b1;
        end else if (w_clr_valid) begin
            r_disp_valid <= 1'b0;
        end
    end

    assign o_r_addr     = r_addr;
    assign o_disp_data  = r_disp_data;
    assign o_disp_addr  = r_disp_addr;
    assign o_disp_valid = r_disp_valid;
    assign o_busy       = (r_state == S_ADDR) || (r_state == S_CAPT) || (r_state == S_HOLD);
    assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_reg_stack_scanner.sv
`timescale 1ns/1ps
module tb_reg_stack_scanner;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int TICK_DIV = 4;
    localparam int DEB      = 8;
    localparam int NREG     = 32;
`ifdef SCANNER_DEBOUNCE_EN
    localparam bit MODEL_EN = 1'b0;
`else
    localparam bit MODEL_EN = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              step = 1'b0;
    logic              auto_sw = 1'b0;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] disp_data;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register stack read port model: reg[i] = 32'h1000_0000 + i.
    assign r_data = 32'h1000_0000 + {27'd0, r_addr};

    reg_stack_scanner #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_step(step), .i_auto(auto_sw),
        .i_r_data(r_data), .o_r_addr(r_addr), .o_disp_data(disp_data),
        .o_disp_addr(disp_addr), .o_disp_valid(disp_valid), .o_busy(busy), .o_done(done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_step(input int hold, input int gap);
        step = 1'b1; idle(hold); step = 1'b0; idle(gap);
    endtask

    task automatic press_start(input int hold, input int gap);
        start = 1'b1; idle(hold); start = 1'b0; idle(gap);
    endtask

    // ---------------- behavioural model ----------------
    // Pin histories (bit 0 = most recent sample); a button pulse reaches the
    // scanner 3 edges after the pin rises, Auto is seen 2 edges after the pin.
    bit [3:0]    h_start, h_step, h_auto;
    bit          p_start, p_step, a_lvl;
    bit          m_busy, m_done, m_valid;
    int          m_addr, m_wait, m_dwell, m_daddr;
    logic [31:0] m_data;

    always @(posedge clk) begin
        if (!rst_n) begin
            h_start = '0; h_step = '0; h_auto = '0;
            m_busy = 0; m_done = 0; m_valid = 0;
            m_addr = 0; m_wait = 0; m_dwell = 0; m_daddr = 0; m_data = '0;
        end else begin
            p_start = h_start[2] & ~h_start[3];
            p_step  = h_step[2] & ~h_step[3];
            a_lvl   = h_auto[1];
            h_start = {h_start[2:0], start};
            h_step  = {h_step[2:0], step};
            h_auto  = {h_auto[2:0], auto_sw};
            if (!m_busy) begin
                if (p_start) begin
                    m_busy = 1; m_done = 0; m_valid = 0; m_addr = 0; m_wait = 2;
                end
            end else if (m_wait > 0) begin
                if (m_wait == 1) begin
                    m_data  = 32'h1000_0000 + m_addr;
                    m_daddr = m_addr;
                    m_valid = 1;
                    m_dwell = 0;
                end
                m_wait--;
            end else if (p_step || (a_lvl && m_dwell == TICK_DIV - 1)) begin
                m_dwell = 0;
                if (m_addr == NREG - 1) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_addr++; m_wait = 2;
                end
            end else if (a_lvl) begin
                m_dwell++;
            end
        end
    end

    logic [44:0] act_vec, exp_vec;
    always @(negedge clk) begin
        if (MODEL_EN) begin
            act_vec = {r_addr, disp_data, disp_addr, disp_valid, busy, done};
            if (!rst_n) exp_vec = '0;
            else exp_vec = {m_addr[4:0], m_data, m_daddr[4:0], m_valid, m_busy, m_done};
            check("cycle_model", {19'd0, act_vec}, {19'd0, exp_vec});
        end
    end

    // ---------------- directed stimulus ----------------
    int t_start;
    int t_seen[NREG];

    initial begin
        rst_n = 1'b0;
        idle(3);
        check("reset_outputs", {19'd0, r_addr, disp_data, disp_addr, disp_valid, busy, done}, 64'd0);
        rst_n = 1'b1;
        idle(3);
`ifdef SCANNER_DEBOUNCE_EN
        press_start(12, 30);
        check("deb_start_busy", busy, 1);
        check("deb_start_addr", {disp_valid, disp_addr}, {1'b1, 5'd0});
        press_step(5, 30);
        check("deb_glitch_no_adv", disp_addr, 0);
        press_step(10, 30);
        check("deb_press_one_adv", disp_addr, 1);
`else
        // Start with Auto low: word 0 appears 6 pin-cycles after the press.
        start = 1'b1; idle(2); start = 1'b0;
        idle(3);
        check("start_valid_early", disp_valid, 0);
        idle(1);
        check("start_data0", disp_data, 32'h1000_0000);
        check("start_addr0", {disp_valid, busy, disp_addr}, {1'b1, 1'b1, 5'd0});
        idle(20);
        check("hold_indef", {busy, done, disp_addr}, {1'b1, 1'b0, 5'd0});

        // Step to address 7, then reset asynchronously mid-HOLD.
        for (int i = 0; i < 7; i++) press_step(2, 6);
        check("step7_addr", disp_addr, 7);
        check("step7_data", disp_data, 32'h1000_0007);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {19'd0, r_addr, disp_data, disp_addr, disp_valid, busy, done}, 64'd0);
        @(negedge clk); idle(2);
        rst_n = 1'b1;
        idle(2);
        press_step(2, 6);
        press_step(2, 6);
        check("step_after_reset", {busy, done, disp_valid, disp_addr}, 8'd0);

        // Full manual scan: 31 steps reach the top, one more finishes.
        press_start(2, 8);
        for (int i = 0; i < 31; i++) press_step(2, 6);
        check("manual_top_addr", disp_addr, 31);
        check("manual_top_data", disp_data, 32'h1000_001F);
        check("manual_top_busy", {busy, done}, 2'b10);
        press_step(2, 6);
        check("manual_done", {busy, done, disp_valid, disp_addr}, {1'b0, 1'b1, 1'b1, 5'd31});

        // Auto scan restarted from DONE, with a Start press mid-scan ignored.
        auto_sw = 1'b1;
        idle(3);
        t_start = cyc;
        start = 1'b1;
        fork
            begin
                idle(2); start = 1'b0;
                idle(30); start = 1'b1;
                idle(2); start = 1'b0;
            end
        join_none
        for (int k = 0; k < NREG; k++) begin
            int w;
            w = 0;
            while (!(disp_valid && disp_addr == k[4:0]) && w < 20) begin
                @(negedge clk); w++;
            end
            check("auto_addr_seen", disp_addr, k);
            t_seen[k] = cyc;
            if (k == 0) check("auto_first_latency", t_seen[0] - t_start, 6);
            else check("auto_dwell", t_seen[k] - t_seen[k-1], TICK_DIV + 2);
        end
        begin
            int w;
            w = 0;
            while (!done && w < 20) begin @(negedge clk); w++; end
        end
        check("auto_done", {busy, done, disp_addr}, {1'b0, 1'b1, 5'd31});

        // Step pulse landing on the same edge as the tick at address 5.
        idle(3);
        start = 1'b1; idle(2); start = 1'b0;
        idle(34);
        check("coinc_at5", disp_addr, 5);
        step = 1'b1; idle(2); step = 1'b0;
        idle(4);
        check("coinc_one_adv", disp_addr, 6);
        idle(5);
        check("coinc_dwell6", disp_addr, 6);
        idle(1);
        check("coinc_next7", disp_addr, 7);
        begin
            int w;
            w = 0;
            while (!done && w < 250) begin @(negedge clk); w++; end
        end
        check("coinc_done", {busy, done, disp_addr}, {1'b0, 1'b1, 5'd31});
`endif
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
